axil_rd_arbiter: RTL and testbench
==================================

# axil_rd_arbiter

Two-master AXI-lite read-channel arbiter that shares one single-port read slave (main RAM) between instruction fetch (master 0) and load/store unit (master 1). Sits between the core's two read ports and the RAM's AR/R channels. Serialises transactions with one outstanding read at a time, round-robin on contention. Holds the granted address stable for the whole transaction, so slaves that drive read data combinationally from the address see a stable address.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte/word address width passed through unchanged
- DATA_WIDTH, core_pkg::DATA_WIDTH (32), read data width

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_araddr  in  ADDR_WIDTH  fetch read address
- m0_arvalid  in  1  fetch address valid
- m0_arready  out  1  fetch address accepted
- m0_rdata  out  DATA_WIDTH  fetch read data
- m0_rvalid  out  1  fetch data valid
- m0_rready  in  1  fetch ready for data
- m1_araddr / m1_arvalid / m1_arready / m1_rdata / m1_rvalid / m1_rready: same as m0, for LSU
- s_araddr  out  ADDR_WIDTH  address to RAM
- s_arvalid  out  1  address valid to RAM
- s_arready  in  1  RAM address accept
- s_rdata  in  DATA_WIDTH  RAM read data
- s_rvalid  in  1  RAM data valid
- s_rready  out  1  ready to RAM

## Operation
- FSM states: ARB_IDLE, ARB_ADDR, ARB_DATA. Registers: state, owner (1 bit), last_grant (1 bit), addr_q.
- ARB_IDLE: if any mX_arvalid, select winner; latch addr_q ← winner araddr, owner ← winner; go ARB_ADDR.
- Selection: only one valid → that one. Both valid → master != last_grant.
- ARB_ADDR: s_arvalid=1; m{owner}_arready=1 for exactly this first ADDR cycle (masters hold arvalid until ready, so handshake completes here). Stay until s_arready=1, then ARB_DATA.
- ARB_DATA: s_rready = m{owner}_rready; m{owner}_rvalid = s_rvalid; both m0_rdata and m1_rdata = s_rdata. Non-owner rvalid=0. On s_rvalid && s_rready: last_grant ← owner, go ARB_IDLE.
- s_araddr = addr_q in every state (never glitches mid-transaction).
- Requests from the non-owner while busy: ignored, arready=0, serviced in next IDLE.
- Owner holds rready low: stay ARB_DATA, s_rready=0, no data lost.

## Timing
- Reset (rst_n low, any state): state=ARB_IDLE, owner=0, last_grant=1 (fetch wins first tie), addr_q=0. All arready, rvalid, s_arvalid, s_rready outputs 0.
- Reset mid-transaction: immediate return to IDLE; in-flight read abandoned, no rvalid issued.
- mX_arready, s_arvalid: registered (state-decoded), no combinational path from mX_arvalid.
- R channel: combinational pass-through gated by state==ARB_DATA and owner.
- Latency with always-ready slave (s_arready=1, s_rvalid=1): arvalid at cycle 0 → arready + s_arvalid cycle 1 → rvalid cycle 2 → IDLE cycle 3, accepts next request cycle 3. Min throughput one read per 3 cycles.
- Back-to-back contention: fetch and LSU strictly alternate.

## Structure
- core_pkg gains: typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA}; localparams ARB_M_FETCH=1'b0, ARB_M_LSU=1'b1.
- One sub-module: rr_arb2 (combinational 2-way round-robin select from req[1:0] and last_grant; outputs gnt_valid, gnt_id).
- FSM, address latch, R-channel muxing in axil_rd_arbiter.

## Test plan
- Single fetch: m0_araddr=0x04, RAM mem[4]=0xDEADBEEF, always-ready slave → m0_arready cycle 1, m0_rvalid with 0xDEADBEEF cycle 2, m1_* stay 0.
- Tie after reset: both arvalid, m0 addr 0x01, m1 addr 0x02 → m0 served first, m1 next; then re-tie → m0 again loses to no one only after m1 served (strict alternation over 4 ties: 0,1,0,1).
- Backpressure: m1 owner, m1_rready=0 for 5 cycles with s_rvalid=1 → s_rready=0, state stays DATA, s_araddr stable; rready=1 → single beat delivered, IDLE next.
- Slow slave: s_arready low 3 cycles → s_arvalid held, m0_arready pulses once only, s_araddr constant.
- Reset in ARB_DATA: rst_n low one cycle → all valids/readies 0 next edge, no rvalid to owner; next request after reset served with fetch priority.
- Non-owner request while busy: m1_arvalid rises during m0 DATA → m1_arready stays 0 until m0 completes, then m1 granted.

Source files
------------

// File: rtl/axil_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-lite read arbiter.
//   AXIL_DATA_WIDTH : default read data width of the core's memory buses
//   arb_state_t     : arbiter FSM states
//   ARB_M_FETCH/LSU : master identifiers used for owner/last_grant
package axil_rd_arbiter_pkg;

  localparam int AXIL_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic ARB_M_FETCH = 1'b0;
  localparam logic ARB_M_LSU   = 1'b1;

endpackage

// File: rtl/axil_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R).
//   araddr/arvalid/arready : address channel
//   rdata/rvalid/rready    : read data channel
// Modports:
//   master : the side that issues reads (drives araddr, arvalid, rready)
//   slave  : the side that answers reads (drives arready, rdata, rvalid)
interface axil_rd_arbiter_if
  import axil_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );

endinterface

// File: rtl/axil_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin selector.
//   req[1:0]   : request per master (bit 0 = fetch, bit 1 = LSU)
//   last_grant : master served most recently
//   gnt_valid  : at least one request present
//   gnt_id     : selected master
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

  // On a tie the master that was not served last wins; otherwise the lone
  // requester wins. With no request gnt_id is don't-care and reads as 0.
  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req == 2'b10) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Two-master AXI-lite read arbiter sharing one read slave, one read in
// flight at a time, round-robin on contention.
//   clk, rst_n : clock and asynchronous active-low reset
//   m0         : fetch read port (slave modport)
//   m1         : LSU read port (slave modport)
//   s          : shared RAM read port (master modport)
module axil_rd_arbiter
  import axil_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  axil_rd_arbiter_if.slave  m0,
  axil_rd_arbiter_if.slave  m1,
  axil_rd_arbiter_if.master s
);

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  gnt_valid;
  logic                  gnt_id;
  logic                  in_data;
  logic                  s_rready_w;
  logic [DATA_WIDTH-1:0] rdata_shared;

  rr_arb2 u_rr_arb2 (
    .req        ({m1.arvalid, m0.arvalid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // arready_q is a one-cycle pulse marking the first ADDR cycle, so the
  // owner's address handshake completes exactly once even if the slave
  // stalls s_arready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_M_FETCH;
      last_grant_q <= ARB_M_LSU;
      arready_q    <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      arready_q    <= arready_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    arready_d    = 1'b0;
    addr_d       = addr_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          owner_d   = gnt_id;
          addr_d    = (gnt_id == ARB_M_LSU) ? m1.araddr : m0.araddr;
          arready_d = 1'b1;
          state_d   = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (s.arready) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (s.rvalid && s_rready_w) begin
          last_grant_d = owner_q;
          state_d      = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Address side is decoded purely from registers.
  assign s.araddr   = addr_q;
  assign s.arvalid  = (state_q == ARB_ADDR);
  assign m0.arready = arready_q && (owner_q == ARB_M_FETCH);
  assign m1.arready = arready_q && (owner_q == ARB_M_LSU);

  // Read data is a combinational pass-through, steered to the owner only.
  assign in_data      = (state_q == ARB_DATA);
  assign s_rready_w   = in_data && ((owner_q == ARB_M_LSU) ? m1.rready : m0.rready);
  assign s.rready     = s_rready_w;
  assign m0.rvalid    = in_data && (owner_q == ARB_M_FETCH) && s.rvalid;
  assign m1.rvalid    = in_data && (owner_q == ARB_M_LSU) && s.rvalid;
  assign rdata_shared = s.rdata;
  assign m0.rdata     = rdata_shared;
  assign m1.rdata     = rdata_shared;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed testbench for axil_rd_arbiter: drives both masters, models a
// combinational RAM slave, and compares outputs to hand-computed values.
module tb_axil_rd_arbiter;
  import axil_rd_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_rready, m1_rready;
  logic        ar_en, r_en;

  logic [31:0] mem [0:255];

  int checks;
  int errors;
  int m0_beats;
  int m1_beats;
  int m0_ar_pulses;

  axil_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  axil_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  axil_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  axil_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if.slave),
    .m1    (m1_if.slave),
    .s     (s_if.master)
  );

  assign m0_if.araddr  = m0_addr;
  assign m0_if.arvalid = m0_valid;
  assign m0_if.rready  = m0_rready;
  assign m1_if.araddr  = m1_addr;
  assign m1_if.arvalid = m1_valid;
  assign m1_if.rready  = m1_rready;

  assign s_if.arready = ar_en;
  assign s_if.rvalid  = r_en;
  assign s_if.rdata   = mem[s_if.araddr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts handshakes a few ns after each negedge, once inputs have settled.
  initial begin
    m0_beats     = 0;
    m1_beats     = 0;
    m0_ar_pulses = 0;
  end
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (m0_if.rvalid && m0_if.rready) m0_beats = m0_beats + 1;
      if (m1_if.rvalid && m1_if.rready) m1_beats = m1_beats + 1;
      if (m0_if.arready) m0_ar_pulses = m0_ar_pulses + 1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                               input logic v1, input logic [31:0] a1);
    m0_valid = v0;
    m0_addr  = a0;
    m1_valid = v1;
    m1_addr  = a1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_m0_arready"}, 32'(m0_if.arready), 32'd0);
    checkOutput({tag, "_m1_arready"}, 32'(m1_if.arready), 32'd0);
    checkOutput({tag, "_m0_rvalid"},  32'(m0_if.rvalid),  32'd0);
    checkOutput({tag, "_m1_rvalid"},  32'(m1_if.rvalid),  32'd0);
    checkOutput({tag, "_s_arvalid"},  32'(s_if.arvalid),  32'd0);
    checkOutput({tag, "_s_rready"},   32'(s_if.rready),   32'd0);
  endtask

  int          base;
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[4] = 32'hDEAD_BEEF;
    exp_addr = '{32'h1, 32'h2, 32'h3, 32'h5};
    exp_data = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0005};

    rst_n     = 1'b0;
    ar_en     = 1'b1;
    r_en      = 1'b1;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    @(negedge clk);
    checkQuiet("rst");
    checkOutput("rst_s_araddr", s_if.araddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch from address 4
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("f_m0_arready", 32'(m0_if.arready), 32'd1);
    checkOutput("f_m1_arready", 32'(m1_if.arready), 32'd0);
    checkOutput("f_s_arvalid",  32'(s_if.arvalid),  32'd1);
    checkOutput("f_s_araddr",   s_if.araddr,        32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("f_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    checkOutput("f_m0_rdata",  m0_if.rdata,       32'hDEAD_BEEF);
    checkOutput("f_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    checkOutput("f_s_rready",  32'(s_if.rready),  32'd1);
    @(negedge clk);
    checkOutput("f_idle_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    checkOutput("f_idle_s_arvalid", 32'(s_if.arvalid), 32'd0);

    // Ties after reset: both masters keep requesting, winners go 0,1,0,1
    doReset();
    applyStimulus(1'b1, 32'h1, 1'b1, 32'h2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tie%0d_m0_arready", k), 32'(m0_if.arready), 32'((k % 2) == 0));
      checkOutput($sformatf("tie%0d_m1_arready", k), 32'(m1_if.arready), 32'((k % 2) == 1));
      checkOutput($sformatf("tie%0d_s_araddr", k), s_if.araddr, exp_addr[k]);
      if ((k % 2) == 0) m0_addr = (k == 0) ? 32'h3 : 32'h7;
      else              m1_addr = (k == 1) ? 32'h5 : 32'h9;
      @(negedge clk);
      checkOutput($sformatf("tie%0d_m0_rvalid", k), 32'(m0_if.rvalid), 32'((k % 2) == 0));
      checkOutput($sformatf("tie%0d_m1_rvalid", k), 32'(m1_if.rvalid), 32'((k % 2) == 1));
      checkOutput($sformatf("tie%0d_rdata", k), m0_if.rdata, exp_data[k]);
      @(negedge clk);
      checkOutput($sformatf("tie%0d_idle_arvalid", k), 32'(s_if.arvalid), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    // Backpressure: LSU owns the bus but holds rready low for 5 cycles
    m1_rready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h30);
    @(negedge clk);
    checkOutput("bp_m1_arready", 32'(m1_if.arready), 32'd1);
    base = m1_beats;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_s_rready", i), 32'(s_if.rready), 32'd0);
      checkOutput($sformatf("bp%0d_state", i), 32'(dut.state_q), 32'(ARB_DATA));
      checkOutput($sformatf("bp%0d_s_araddr", i), s_if.araddr, 32'h30);
    end
    checkOutput("bp_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    checkOutput("bp_m1_rdata",  m1_if.rdata,       32'hA000_0030);
    m1_rready = 1'b1;
    @(negedge clk);
    checkOutput("bp_beats", 32'(m1_beats - base), 32'd1);
    checkOutput("bp_idle_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    checkOutput("bp_idle_state", 32'(dut.state_q), 32'(ARB_IDLE));

    // Slow slave: s_arready low over three sampled ADDR edges
    ar_en = 1'b0;
    base  = m0_ar_pulses;
    applyStimulus(1'b1, 32'h8, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("ss_m0_arready", 32'(m0_if.arready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ss%0d_m0_arready", i), 32'(m0_if.arready), 32'd0);
      checkOutput($sformatf("ss%0d_s_arvalid", i), 32'(s_if.arvalid), 32'd1);
      checkOutput($sformatf("ss%0d_s_araddr", i), s_if.araddr, 32'h8);
    end
    ar_en = 1'b1;
    @(negedge clk);
    checkOutput("ss_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    checkOutput("ss_m0_rdata",  m0_if.rdata,       32'hA000_0008);
    @(negedge clk);
    checkOutput("ss_ar_pulses", 32'(m0_ar_pulses - base), 32'd1);

    // Non-owner request while fetch holds the bus
    m0_rready = 1'b0;
    applyStimulus(1'b1, 32'hC, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("no_m0_arready", 32'(m0_if.arready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("no_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40);
    @(negedge clk);
    checkOutput("no_busy_m1_arready", 32'(m1_if.arready), 32'd0);
    checkOutput("no_busy_s_araddr",   s_if.araddr,        32'hC);
    m0_rready = 1'b1;
    @(negedge clk);
    checkOutput("no_idle_m1_arready", 32'(m1_if.arready), 32'd0);
    @(negedge clk);
    checkOutput("no_m1_arready", 32'(m1_if.arready), 32'd1);
    checkOutput("no_s_araddr",   s_if.araddr,        32'h40);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("no_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    checkOutput("no_m1_rdata",  m1_if.rdata,       32'hA000_0040);
    @(negedge clk);

    // Reset while LSU read sits in ARB_DATA
    m1_rready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h50);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rd_m1_rvalid_pre", 32'(m1_if.rvalid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkQuiet("rd");
    checkOutput("rd_s_araddr", s_if.araddr, 32'h0);
    rst_n     = 1'b1;
    m1_rready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 32'h60, 1'b1, 32'h61);
    @(negedge clk);
    checkOutput("rd_tie_m0_arready", 32'(m0_if.arready), 32'd1);
    checkOutput("rd_tie_m1_arready", 32'(m1_if.arready), 32'd0);
    checkOutput("rd_tie_s_araddr",   s_if.araddr,        32'h60);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rd_tie_m0_rdata", m0_if.rdata, 32'hA000_0060);
    checkOutput("rd_tie_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    @(negedge clk);
    checkOutput("rd_tie_idle_arvalid", 32'(s_if.arvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
